// File: rtl/bht_pkg.sv
// bht_pkg: shared FSM states, counter constants, saturating update and FIFO entry type for the BHT.
package bht_pkg;
  localparam int BHT_IDX_W = 4;
  localparam logic [1:0] SNT = 2'd0, WNT = 2'd1, WT = 2'd2, ST = 2'd3;
  typedef enum logic {INIT, RUN} state_t;
  typedef struct packed {
    logic [BHT_IDX_W-1:0] idx;
    logic                 taken;
  } upd_t;
  function automatic logic [1:0] sat_next(input logic [1:0] s, input logic t);
    return t ? (s == ST ? ST : s + 2'd1) : (s == SNT ? SNT : s - 2'd1);
  endfunction
endpackage

// File: rtl/bht_update_fifo.sv
// bht_update_fifo: synchronous FIFO of resolved outcomes awaiting a free table slot.
module bht_update_fifo import bht_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  upd_t                       din,
  output upd_t                       dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  upd_t mem [DEPTH];
  logic [AW-1:0] wr, rd;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout  = mem[rd];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;
endmodule

// File: rtl/bht_controller.sv
// bht_controller: 2-bit branch history table sharing one access slot between lookups and queued updates.
// Define BHT_BYPASS_EN to apply an outcome directly when the FIFO is empty and the slot is idle.
module bht_controller import bht_pkg::*; #(
  parameter int         IDX_W      = BHT_IDX_W,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] INIT_STATE = ST
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  input  logic [IDX_W-1:0]              req_idx,
  output logic                          req_ready,
  output logic                          pred_valid,
  output logic                          pred_taken,
  output logic [1:0]                    pred_state,
  input  logic                          res_valid,
  input  logic [IDX_W-1:0]              res_idx,
  input  logic                          res_taken,
  output logic                          res_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          init_done
);
  logic [1:0] tbl [2**IDX_W];
  state_t state;
  logic [IDX_W-1:0] ptr;
  logic run, full, empty, lookup, res_acc, bypass, push, pop;
  upd_t head, din;
  assign run       = state == RUN;
  assign init_done = run;
  assign req_ready = run & !full;
  assign res_ready = run & !full;
  assign lookup    = req_valid & req_ready;
  assign res_acc   = res_valid & res_ready;
`ifdef BHT_BYPASS_EN
  assign bypass    = res_acc & empty & !lookup;
`else
  assign bypass    = 1'b0;
`endif
  assign push      = res_acc & !bypass;
  // full forces lookup low, so the head drains whenever the slot is not taken by a lookup
  assign pop       = run & !lookup & !empty;
  assign din       = '{idx: res_idx, taken: res_taken};
  assign pred_taken = pred_state[1];
  bht_update_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
    .dout(head), .full(full), .empty(empty), .count(fifo_count)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= INIT;
      ptr   <= '0;
    end else if (!run) begin
      ptr <= ptr + 1'b1;
      if (ptr == '1) state <= RUN;
    end
  always_ff @(posedge clk)
    if (!run) tbl[ptr] <= INIT_STATE;
    else if (pop) tbl[head.idx] <= sat_next(tbl[head.idx], head.taken);
    else if (bypass) tbl[res_idx] <= sat_next(tbl[res_idx], res_taken);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pred_valid <= 1'b0;
      pred_state <= '0;
    end else begin
      pred_valid <= lookup;
      if (lookup) pred_state <= tbl[req_idx];
    end
endmodule

// File: tb/tb_bht_controller.sv
// tb_bht_controller: directed self-checking bench for bht_controller (both BHT_BYPASS_EN builds).
module tb_bht_controller;
  logic clk = 0, rst = 1;
  logic req_valid = 0, res_valid = 0, res_taken = 0;
  logic [3:0] req_idx = 0, res_idx = 0;
  logic req_ready, pred_valid, pred_taken, res_ready, init_done;
  logic [1:0] pred_state;
  logic [2:0] fifo_count;
  int tests = 0, fails = 0;

  bht_controller dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_idx(req_idx), .req_ready(req_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_state(pred_state),
    .res_valid(res_valid), .res_idx(res_idx), .res_taken(res_taken), .res_ready(res_ready),
    .fifo_count(fifo_count), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [3:0] idx, output logic [1:0] st, output logic v);
    req_valid = 1; req_idx = idx;
    tick;
    req_valid = 0;
    st = pred_state; v = pred_valid;
  endtask

  task automatic update(input logic [3:0] idx, input logic t);
    res_valid = 1; res_idx = idx; res_taken = t;
    tick;
    res_valid = 0;
    tick;
  endtask

  task automatic wait_init(input string name);
    int n = 0, busy = 0;
    while (!init_done && n < 100) begin
      if (req_ready || res_ready) busy++;
      tick;
      n++;
    end
    tests++;
    if (n != 16 || busy != 0) begin
      fails++;
      $display("FAIL %s: init cycles=%0d ready_during_init=%0d, expected 16 and 0", name, n, busy);
    end
  endtask

  task automatic test_reset;
    tests++;
    if ({init_done, req_ready, res_ready, pred_valid, fifo_count} !== 7'b0) begin
      fails++;
      $display("FAIL reset_state: got %b expected 0", {init_done, req_ready, res_ready, pred_valid, fifo_count});
    end
    rst = 0;
    wait_init("init_len");
  endtask

  task automatic test_init_contents;
    int bad = 0;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1; req_idx = 4'(i);
      tick;
      if (!pred_valid || pred_state !== 2'd3 || pred_taken !== 1'b1) bad++;
    end
    req_valid = 0;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL init_contents: %0d entries wrong, expected all state 3", bad);
    end
    tick;
    tests++;
    if (pred_valid !== 1'b0 || pred_state !== 2'd3) begin
      fails++;
      $display("FAIL pred_hold: valid=%b state=%0d expected 0 and 3", pred_valid, pred_state);
    end
  endtask

  task automatic test_saturation;
    logic [1:0] st; logic v;
    for (int i = 0; i < 4; i++) update(5, 0);
    lookup(5, st, v);
    tests++;
    if (st !== 2'd0 || !v) begin fails++; $display("FAIL sat_low: got %0d expected 0", st); end
    update(5, 1);
    lookup(5, st, v);
    tests++;
    if (st !== 2'd1 || pred_taken !== 1'b0) begin
      fails++; $display("FAIL sat_inc: got %0d taken=%b expected 1 taken=0", st, pred_taken);
    end
    for (int i = 0; i < 3; i++) update(5, 1);
    lookup(5, st, v);
    tests++;
    if (st !== 2'd3 || pred_taken !== 1'b1) begin
      fails++; $display("FAIL sat_high: got %0d expected 3", st);
    end
  endtask

  task automatic test_fifo_full;
    logic [1:0] st; logic v;
    req_valid = 1; req_idx = 0;
    res_valid = 1; res_idx = 9; res_taken = 0;
    repeat (4) tick;
    res_valid = 0;
    tests++;
    if (fifo_count !== 3'd4 || res_ready !== 1'b0 || req_ready !== 1'b0) begin
      fails++; $display("FAIL full_state: count=%0d res_ready=%b req_ready=%b expected 4 0 0", fifo_count, res_ready, req_ready);
    end
    tick;
    tests++;
    if (fifo_count !== 3'd3 || pred_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL full_drain: count=%0d pred_valid=%b req_ready=%b expected 3 0 1", fifo_count, pred_valid, req_ready);
    end
    tick;
    tests++;
    if (fifo_count !== 3'd3 || pred_valid !== 1'b1) begin
      fails++; $display("FAIL lookup_blocks_drain: count=%0d pred_valid=%b expected 3 1", fifo_count, pred_valid);
    end
    res_valid = 1;
    tick;
    tests++;
    if (fifo_count !== 3'd4) begin fails++; $display("FAIL refill: count=%0d expected 4", fifo_count); end
    req_valid = 0;
    res_valid = 0;
    tick;
    res_valid = 1;
    tick;
    res_valid = 0;
    tests++;
    if (fifo_count !== 3'd3) begin fails++; $display("FAIL push_pop: count=%0d expected 3", fifo_count); end
    repeat (3) tick;
    tests++;
    if (fifo_count !== 3'd0) begin fails++; $display("FAIL drain_empty: count=%0d expected 0", fifo_count); end
    lookup(9, st, v);
    tests++;
    if (st !== 2'd0) begin fails++; $display("FAIL full_result: idx9=%0d expected 0", st); end
  endtask

  task automatic test_same_index;
    logic [1:0] st; logic v;
    req_valid = 1; req_idx = 7;
    res_valid = 1; res_idx = 7; res_taken = 0;
    tick;
    req_valid = 0; res_valid = 0;
    tests++;
    if (pred_state !== 2'd3 || fifo_count !== 3'd1) begin
      fails++; $display("FAIL same_idx_lookup: state=%0d count=%0d expected 3 1", pred_state, fifo_count);
    end
    tick;
    lookup(7, st, v);
    tests++;
    if (st !== 2'd2) begin fails++; $display("FAIL same_idx_after: got %0d expected 2", st); end
  endtask

  task automatic test_reset_mid_run;
    logic [1:0] st; logic v;
    int bad = 0;
    req_valid = 1; req_idx = 0;
    res_valid = 1; res_idx = 3; res_taken = 0;
    repeat (3) tick;
    req_valid = 0; res_valid = 0;
    tests++;
    if (fifo_count !== 3'd3) begin fails++; $display("FAIL queued3: count=%0d expected 3", fifo_count); end
    rst = 1;
    #1;
    tests++;
    if (fifo_count !== 3'd0 || pred_valid !== 1'b0 || init_done !== 1'b0) begin
      fails++; $display("FAIL mid_reset: count=%0d pred_valid=%b init_done=%b expected 0 0 0", fifo_count, pred_valid, init_done);
    end
    tick;
    rst = 0;
    wait_init("reinit_len");
    for (int i = 0; i < 16; i++) begin
      lookup(4'(i), st, v);
      if (st !== 2'd3 || !v) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL reinit_contents: %0d entries wrong, expected all 3", bad); end
  endtask

  task automatic test_bypass;
    logic [1:0] st; logic v;
    res_valid = 1; res_idx = 2; res_taken = 0;
    tick;
    res_valid = 0;
    tests++;
`ifdef BHT_BYPASS_EN
    if (fifo_count !== 3'd0) begin fails++; $display("FAIL bypass_count: count=%0d expected 0", fifo_count); end
`else
    if (fifo_count !== 3'd1) begin fails++; $display("FAIL enqueue_count: count=%0d expected 1", fifo_count); end
    tick;
`endif
    lookup(2, st, v);
    tests++;
    if (st !== 2'd2 || fifo_count !== 3'd0) begin
      fails++; $display("FAIL bypass_result: state=%0d count=%0d expected 2 0", st, fifo_count);
    end
  endtask

  initial begin
    #12;
    test_reset;
    test_init_contents;
    test_saturation;
    test_fifo_full;
    test_same_index;
    test_reset_mid_run;
    test_bypass;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
